traffic_light_ctrl_p: RTL and testbench
=======================================

// Module: traffic_light_ctrl_p
// PURPOSE
//  Parametrised two-direction traffic-light controller; successor of the fixed 1-cycle 4-phase controller.
//  Per-phase programmable durations, all-red clearance, pedestrian early-green-termination, night flashing-yellow mode.
//  Drives lamp outputs directly; also exports phase/countdown for a display block.
// PARAMETERS
//  CNT_W      8  width of phase counter and remain output
//  GREEN_T    5  green duration, cycles (>=1, >=MIN_GREEN)
//  YELLOW_T   2  yellow duration, cycles (>=1)
//  ALL_RED_T  1  all-red clearance duration, cycles (>=1)
//  MIN_GREEN  2  minimum green before a ped request may cut it (>=1)
//  FLASH_T    3  half-period of night flashing, cycles (>=1)
// PORTS
//  clk      in   1      clock
//  reset    in   1      asynchronous, active-low
//  night    in   1      level; request flashing-yellow mode
//  ped_req  in   1      pulse/level; pedestrian crossing request
//  lt1      out  3      dir-1 lamps {red,yellow,green}
//  lt2      out  3      dir-2 lamps {red,yellow,green}
//  phase    out  3      current state encoding (below)
//  remain   out  CNT_W  cycles left in phase incl. current (T-cnt); 0 in IDLE/FLASH
//  ped_pend out  1      pedestrian request latched, not yet served
// BEHAVIOUR
//  States: IDLE=0 A_GRN=1 A_YEL=2 AR1=3 B_GRN=4 B_YEL=5 AR2=6 FLASH=7.
//  Lamps: A_GRN lt1=001 lt2=100; A_YEL 010/100; AR1,AR2 100/100; B_GRN 100/001; B_YEL 100/010.
//  All outputs registered; lamps update on same edge as state. Undefined codes -> IDLE.
//  Reset (async, low): state=IDLE, lt1=lt2=010, cnt=0, ped_pend=0, flash_ph=0.
//  IDLE: one cycle, then A_GRN unconditionally (night ignored here).
//  cnt: elapsed cycles in state; cleared to 0 on every transition, else +1. Never wraps (T<2^CNT_W).
//  Phase length T: GRN=GREEN_T, YEL=YELLOW_T, AR=ALL_RED_T. Exit when cnt==T-1.
//  Sequence: A_GRN->A_YEL->AR1->B_GRN->B_YEL->AR2->A_GRN; full cycle 2*(G+Y+AR) cycles.
//  Ped: ped_pend sets on any edge with ped_req=1; clears on entry to AR1/AR2 (set wins if ped_req=1 that edge).
//  Green early exit: in X_GRN leave when (ped_pend|ped_req) && cnt>=MIN_GREEN-1, or cnt==GREEN_T-1.
//  Yellow/all-red never shortened by ped.
//  Night: sampled only at last cycle of AR1/AR2; if 1 -> FLASH instead of next green.
//  FLASH: lt1=lt2=010 when flash_ph=1 else 000; entry sets flash_ph=1,cnt=0; toggle flash_ph and clear cnt when cnt==FLASH_T-1.
//  FLASH exit: night sampled 0 at any cycle -> AR2 (lamps 100/100), then A_GRN. ped_pend held, not served in FLASH.
//  remain: T-cnt for timed states; 0 in IDLE and FLASH.
//  Reset mid-phase: immediate return to reset values regardless of state/cnt.
// TESTING (defaults unless noted)
//  1 release reset -> edge1 IDLE->A_GRN lt1=001 lt2=100 remain=5; A_YEL at edge6, AR1 at 8, B_GRN at 9; period 16.
//  2 ped_req 1-cycle pulse at A_GRN cnt=0 -> ped_pend=1; A_YEL entered after cnt=1 (green lasts 2); ped_pend=0 on AR1 entry.
//  3 ped_req during A_YEL -> yellow still 2 cycles; B_GRN truncated to MIN_GREEN=2 cycles.
//  4 night=1 held from A_GRN -> full A_GRN/A_YEL/AR1, then FLASH: both 010 for 3 cycles, 000 for 3, repeat; remain=0.
//  5 drop night in FLASH -> next edge AR2 100/100 for 1 cycle, then A_GRN 001/100.
//  6 assert reset mid-B_GRN (cnt=3) -> immediately lt1=lt2=010, phase=0, ped_pend=0; release reproduces test 1.

Source files
------------

// File: rtl/traffic_light_ctrl_p.sv
// Two-direction traffic-light controller with programmable phase lengths,
// pedestrian early green termination and a night flashing-yellow mode.
module traffic_light_ctrl_p #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned GREEN_T   = 5,
    parameter int unsigned YELLOW_T  = 2,
    parameter int unsigned ALL_RED_T = 1,
    parameter int unsigned MIN_GREEN = 2,
    parameter int unsigned FLASH_T   = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             night,
    input  logic             ped_req,
    output logic [2:0]       lt1,
    output logic [2:0]       lt2,
    output logic [2:0]       phase,
    output logic [CNT_W-1:0] remain,
    output logic             ped_pend
);

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        A_GRN = 3'd1,
        A_YEL = 3'd2,
        AR1   = 3'd3,
        B_GRN = 3'd4,
        B_YEL = 3'd5,
        AR2   = 3'd6,
        FLASH = 3'd7
    } state_t;

    localparam logic [CNT_W-1:0] L_GRN_T   = CNT_W'(GREEN_T);
    localparam logic [CNT_W-1:0] L_YEL_T   = CNT_W'(YELLOW_T);
    localparam logic [CNT_W-1:0] L_AR_T    = CNT_W'(ALL_RED_T);
    localparam logic [CNT_W-1:0] L_GRN_END = CNT_W'(GREEN_T - 1);
    localparam logic [CNT_W-1:0] L_YEL_END = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] L_AR_END  = CNT_W'(ALL_RED_T - 1);
    localparam logic [CNT_W-1:0] L_MIN_END = CNT_W'(MIN_GREEN - 1);
    localparam logic [CNT_W-1:0] L_FL_END  = CNT_W'(FLASH_T - 1);

    state_t           r_state;
    state_t           w_nxt_state;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_nxt_cnt;
    logic             r_flash_ph;
    logic             w_nxt_flash_ph;
    logic             r_ped_pend;
    logic             w_nxt_pend;
    logic             w_ped_any;
    logic             w_ar_entry;
    logic [5:0]       w_nxt_lamps;
    logic [CNT_W-1:0] w_nxt_remain;
    logic [2:0]       r_lt1;
    logic [2:0]       r_lt2;
    logic [CNT_W-1:0] r_remain;

    always_comb begin
        w_nxt_state    = r_state;
        w_nxt_cnt      = r_cnt + 1'b1;
        w_nxt_flash_ph = r_flash_ph;
        w_ped_any      = r_ped_pend | ped_req;
        case (r_state)
            IDLE: w_nxt_state = A_GRN;
            A_GRN, B_GRN: begin
                if ((w_ped_any && (r_cnt >= L_MIN_END)) || (r_cnt == L_GRN_END))
                    w_nxt_state = (r_state == A_GRN) ? A_YEL : B_YEL;
            end
            A_YEL: if (r_cnt == L_YEL_END) w_nxt_state = AR1;
            B_YEL: if (r_cnt == L_YEL_END) w_nxt_state = AR2;
            AR1, AR2: begin
                if (r_cnt == L_AR_END) begin
                    if (night) begin
                        w_nxt_state    = FLASH;
                        w_nxt_flash_ph = 1'b1;
                    end else begin
                        w_nxt_state = (r_state == AR1) ? B_GRN : A_GRN;
                    end
                end
            end
            FLASH: begin
                if (!night) begin
                    w_nxt_state = AR2;
                end else if (r_cnt == L_FL_END) begin
                    w_nxt_flash_ph = ~r_flash_ph;
                    w_nxt_cnt      = '0;
                end
            end
            default: w_nxt_state = IDLE;
        endcase
        if (w_nxt_state != r_state)
            w_nxt_cnt = '0;

        // A request arriving on the same edge as the all-red entry survives it.
        w_ar_entry = (w_nxt_state != r_state) && ((w_nxt_state == AR1) || (w_nxt_state == AR2));
        w_nxt_pend = ped_req | (r_ped_pend & ~w_ar_entry);

        w_nxt_lamps  = 6'b010_010;
        w_nxt_remain = '0;
        case (w_nxt_state)
            A_GRN: begin w_nxt_lamps = 6'b001_100; w_nxt_remain = L_GRN_T - w_nxt_cnt; end
            A_YEL: begin w_nxt_lamps = 6'b010_100; w_nxt_remain = L_YEL_T - w_nxt_cnt; end
            AR1:   begin w_nxt_lamps = 6'b100_100; w_nxt_remain = L_AR_T  - w_nxt_cnt; end
            B_GRN: begin w_nxt_lamps = 6'b100_001; w_nxt_remain = L_GRN_T - w_nxt_cnt; end
            B_YEL: begin w_nxt_lamps = 6'b100_010; w_nxt_remain = L_YEL_T - w_nxt_cnt; end
            AR2:   begin w_nxt_lamps = 6'b100_100; w_nxt_remain = L_AR_T  - w_nxt_cnt; end
            FLASH: w_nxt_lamps = w_nxt_flash_ph ? 6'b010_010 : 6'b000_000;
            default: w_nxt_lamps = 6'b010_010;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_cnt      <= '0;
            r_flash_ph <= 1'b0;
            r_ped_pend <= 1'b0;
            r_lt1      <= 3'b010;
            r_lt2      <= 3'b010;
            r_remain   <= '0;
        end else begin
            r_state    <= w_nxt_state;
            r_cnt      <= w_nxt_cnt;
            r_flash_ph <= w_nxt_flash_ph;
            r_ped_pend <= w_nxt_pend;
            r_lt1      <= w_nxt_lamps[5:3];
            r_lt2      <= w_nxt_lamps[2:0];
            r_remain   <= w_nxt_remain;
        end
    end

    assign lt1      = r_lt1;
    assign lt2      = r_lt2;
    assign phase    = r_state;
    assign remain   = r_remain;
    assign ped_pend = r_ped_pend;

endmodule

// File: tb/tb_traffic_light_ctrl_p.sv
// Directed bench for traffic_light_ctrl_p at default parameters:
// normal cycle, pedestrian truncation, night flashing and mid-phase reset.
module tb_traffic_light_ctrl_p;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       night = 1'b0;
    logic       ped_req = 1'b0;
    logic [2:0] lt1, lt2, phase;
    logic [7:0] remain;
    logic       ped_pend;

    int n_checks = 0;
    int n_errors = 0;

    // Expected phase and remain after edges 1..17 following reset release.
    int exp_ph [1:17] = '{1,1,1,1,1,2,2,3,4,4,4,4,4,5,5,6,1};
    int exp_rm [1:17] = '{5,4,3,2,1,2,1,1,5,4,3,2,1,2,1,1,5};

    traffic_light_ctrl_p #(
        .CNT_W(8), .GREEN_T(5), .YELLOW_T(2), .ALL_RED_T(1), .MIN_GREEN(2), .FLASH_T(3)
    ) dut (
        .clk(clk), .reset(reset), .night(night), .ped_req(ped_req),
        .lt1(lt1), .lt2(lt2), .phase(phase), .remain(remain), .ped_pend(ped_pend)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [5:0] lamps_for(input int ph);
        case (ph)
            1:       return 6'b001_100;
            2:       return 6'b010_100;
            3, 6:    return 6'b100_100;
            4:       return 6'b100_001;
            5:       return 6'b100_010;
            default: return 6'b010_010;
        endcase
    endfunction

    task automatic run_period(input string tag);
        for (int e = 1; e <= 17; e++) begin
            tick();
            check({tag, "_phase"}, 16'(phase), 16'(exp_ph[e]));
            check({tag, "_lamps"}, 16'({lt1, lt2}), 16'(lamps_for(exp_ph[e])));
            check({tag, "_remain"}, 16'(remain), 16'(exp_rm[e]));
        end
    endtask

    initial begin
        #12;
        check("rst_phase", 16'(phase), 16'd0);
        check("rst_lamps", 16'({lt1, lt2}), 16'(6'b010_010));
        check("rst_remain", 16'(remain), 16'd0);
        check("rst_pend", 16'(ped_pend), 16'd0);
        reset = 1'b1;

        run_period("t1");

        // Pedestrian pulse at A_GRN cnt=0: green cut to MIN_GREEN.
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        check("t2_pend_set", 16'(ped_pend), 16'd1);
        check("t2_still_grn", 16'(phase), 16'd1);
        tick();
        check("t2_yel_early", 16'(phase), 16'd2);
        tick();
        check("t2_pend_hold", 16'(ped_pend), 16'd1);
        tick();
        check("t2_ar1", 16'(phase), 16'd3);
        check("t2_pend_clr", 16'(ped_pend), 16'd0);

        // Request held across yellow into all-red: next green truncated.
        for (int i = 0; i < 6; i++) tick();
        check("t3_byel", 16'(phase), 16'd5);
        ped_req = 1'b1;
        tick();
        check("t3_yel_full", 16'(phase), 16'd5);
        check("t3_pend", 16'(ped_pend), 16'd1);
        tick();
        ped_req = 1'b0;
        check("t3_ar2", 16'(phase), 16'd6);
        check("t3_pend_wins", 16'(ped_pend), 16'd1);
        tick();
        check("t3_grn0", 16'(phase), 16'd1);
        tick();
        check("t3_grn1", 16'(phase), 16'd1);
        tick();
        check("t3_cut", 16'(phase), 16'd2);
        tick();
        tick();
        check("t3_ar1", 16'(phase), 16'd3);
        check("t3_pend_clr", 16'(ped_pend), 16'd0);

        // Night mode: full phases until all-red, then flashing yellow.
        tick();
        night = 1'b1;
        for (int i = 0; i < 4; i++) tick();
        check("t4_grn_full", 16'(phase), 16'd4);
        tick();
        check("t4_byel", 16'(phase), 16'd5);
        tick();
        tick();
        check("t4_ar2", 16'(phase), 16'd6);
        tick();
        check("t4_flash", 16'(phase), 16'd7);
        check("t4_on0", 16'({lt1, lt2}), 16'(6'b010_010));
        check("t4_remain", 16'(remain), 16'd0);
        tick();
        tick();
        check("t4_on2", 16'({lt1, lt2}), 16'(6'b010_010));
        tick();
        check("t4_off0", 16'({lt1, lt2}), 16'(6'b000_000));
        tick();
        ped_req = 1'b1;
        tick();
        ped_req = 1'b0;
        check("t4_off2", 16'({lt1, lt2}), 16'(6'b000_000));
        check("t4_pend_flash", 16'(ped_pend), 16'd1);
        tick();
        check("t4_on_again", 16'({lt1, lt2}), 16'(6'b010_010));
        check("t4_pend_held", 16'(ped_pend), 16'd1);
        check("t4_still_flash", 16'(phase), 16'd7);

        // Leave night mode: all-red clearance then A green.
        night = 1'b0;
        tick();
        check("t5_ar2", 16'(phase), 16'd6);
        check("t5_ar2_lamps", 16'({lt1, lt2}), 16'(6'b100_100));
        check("t5_ar2_remain", 16'(remain), 16'd1);
        tick();
        check("t5_agrn", 16'(phase), 16'd1);
        check("t5_agrn_lamps", 16'({lt1, lt2}), 16'(6'b001_100));
        check("t5_agrn_remain", 16'(remain), 16'd5);

        // Asynchronous reset in the middle of B_GRN.
        for (int i = 0; i < 11; i++) tick();
        check("t6_bgrn", 16'(phase), 16'd4);
        check("t6_remain_pre", 16'(remain), 16'd2);
        #2 reset = 1'b0;
        #1;
        check("t6_async_phase", 16'(phase), 16'd0);
        check("t6_async_lamps", 16'({lt1, lt2}), 16'(6'b010_010));
        check("t6_async_remain", 16'(remain), 16'd0);
        check("t6_async_pend", 16'(ped_pend), 16'd0);
        tick();
        check("t6_held", 16'(phase), 16'd0);
        #3 reset = 1'b1;
        run_period("t6");

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
